// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: branch redirect and stall inputs, the instruction-memory
// req/ack handshake, and the {instr, pc, valid} bundle handed to decode.
interface fetch_stage_if;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  modport master (
    input  br_taken, br_target, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_instr, if_pc, if_valid
  );

  modport slave (
    output br_taken, br_target, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_instr, if_pc, if_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// squashes wrong-path fetches on a branch redirect and parks one returning
// fetch in a skid buffer while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {FETCH, DISCARD} state_e;

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic        ack_v;
  logic        hold;
  logic [31:0] target;

  // Next-state: redirect first, then output register / skid buffer, then request.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;

    ack_v  = req_q & bus.imem_ack;
    hold   = req_q & ~bus.imem_ack;
    target = bus.br_target & ~32'h3;

    if (bus.br_taken) begin
      pc_d        = target;
      if_valid_d  = 1'b0;
      if_instr_d  = NOP_INSTR;
      buf_valid_d = 1'b0;
      // An unacked request must still be drained at its old address.
      state_d     = hold ? DISCARD : FETCH;
    end else begin
      if (!bus.stall && buf_valid_q) begin
        if_valid_d  = 1'b1;
        if_instr_d  = buf_instr_q;
        if_pc_d     = buf_pc_q;
        buf_valid_d = 1'b0;
      end else if (state_q == FETCH && ack_v && (!bus.stall || !if_valid_q)) begin
        if_valid_d = 1'b1;
        if_instr_d = bus.imem_rdata;
        if_pc_d    = pc_q;
      end else if (!bus.stall) begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end

      if (state_q == FETCH && ack_v) begin
        pc_d = pc_q + 32'd4;
        if (bus.stall && if_valid_q) begin
          buf_valid_d = 1'b1;
          buf_instr_d = bus.imem_rdata;
          buf_pc_d    = pc_q;
        end
      end

      if (state_q == DISCARD && ack_v) state_d = FETCH;
    end

    // Request is held stable until acked; a new one starts only with room downstream.
    if (hold) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = !buf_valid_d && !(bus.stall && if_valid_d);
      addr_d = pc_d;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      req_q       <= 1'b0;
      addr_q      <= PC_INIT;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table, a reset-mid-request
// sequence, and a randomized run against an in-order program-stream model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic a,
                     input logic [31:0] rd, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ei, input logic er, input logic [31:0] ea);
    vec_t v;
    v = '{s, b, t, a, rd, ev, epc, ei, er, ea};
    vq.push_back(v);
  endtask

  // Instruction memory contents for the random run: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] rd);
    bus.stall      = s;
    bus.br_taken   = b;
    bus.br_target  = t;
    bus.imem_ack   = a;
    bus.imem_rdata = rd;
  endtask

  initial begin
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr, exp_pc, tgt_v, rdata_v;
    logic        stall_v, br_v, ack_v;
    int          lat, consumed;

    drive(1'b0, 1'b0, '0, 1'b0, '0);

    // Reset state
    #12;
    chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, NOP);
    chk("rst_pc",    bus.if_pc, 32'd0);

    //   stall br  tgt           ack rdata          ev   epc           einstr         req  addr
    add(0, 0, 0,            0, 0,            0, 0,            NOP,           1, 32'h0);
    add(0, 0, 0,            1, 32'h1000,     1, 32'h0,        32'h1000,      1, 32'h4);
    add(0, 0, 0,            1, 32'h1004,     1, 32'h4,        32'h1004,      1, 32'h8);
    add(0, 0, 0,            0, 32'hEEEE,     0, 0,            NOP,           1, 32'h8);
    add(0, 0, 0,            0, 32'hEEEE,     0, 0,            NOP,           1, 32'h8);
    add(0, 0, 0,            1, 32'h1008,     1, 32'h8,        32'h1008,      1, 32'hC);
    add(1, 0, 0,            1, 32'h100C,     1, 32'h8,        32'h1008,      0, 0);
    add(1, 0, 0,            1, 32'hBAD0,     1, 32'h8,        32'h1008,      0, 0);
    add(0, 0, 0,            0, 0,            1, 32'hC,        32'h100C,      1, 32'h10);
    add(0, 0, 0,            0, 0,            0, 0,            NOP,           1, 32'h10);
    add(0, 1, 32'h102,      0, 0,            0, 0,            NOP,           1, 32'h10);
    add(0, 0, 0,            0, 0,            0, 0,            NOP,           1, 32'h10);
    add(0, 0, 0,            1, 32'hDEAD,     0, 0,            NOP,           1, 32'h100);
    add(0, 0, 0,            1, 32'h2100,     1, 32'h100,      32'h2100,      1, 32'h104);
    add(0, 1, 32'h203,      1, 32'hBAD1,     0, 0,            NOP,           1, 32'h200);
    add(1, 0, 0,            1, 32'h2200,     1, 32'h200,      32'h2200,      0, 0);
    add(0, 0, 0,            0, 0,            0, 0,            NOP,           1, 32'h204);
    add(1, 0, 0,            1, 32'h2204,     1, 32'h204,      32'h2204,      0, 0);
    add(1, 1, 32'h102,      0, 0,            0, 0,            NOP,           1, 32'h100);
    add(0, 0, 0,            0, 0,            0, 0,            NOP,           1, 32'h100);
    add(0, 1, 32'hFFFF_FFFC, 1, 32'hBAD2,    0, 0,            NOP,           1, 32'hFFFF_FFFC);
    add(0, 0, 0,            1, 32'h3000,     1, 32'hFFFF_FFFC, 32'h3000,     1, 32'h0);
    add(0, 0, 0,            1, 32'h3004,     1, 32'h0,        32'h3004,      1, 32'h4);
    add(0, 0, 0,            0, 0,            0, 0,            NOP,           1, 32'h4);
    add(0, 1, 32'h80,       0, 0,            0, 0,            NOP,           1, 32'h4);
    add(0, 1, 32'h90,       0, 0,            0, 0,            NOP,           1, 32'h4);
    add(0, 0, 0,            1, 32'hBAD3,     0, 0,            NOP,           1, 32'h90);
    add(0, 0, 0,            1, 32'h4090,     1, 32'h90,       32'h4090,      1, 32'h94);

    @(negedge clk);
    rst = 1'b0;
    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].br, vq[i].tgt, vq[i].ack, vq[i].rdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, bus.if_valid}, {31'b0, vq[i].ev});
      chk($sformatf("v%0d_instr", i), bus.if_instr, vq[i].einstr);
      if (vq[i].ev) chk($sformatf("v%0d_pc", i), bus.if_pc, vq[i].epc);
      chk($sformatf("v%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vq[i].ereq});
      if (vq[i].ereq) chk($sformatf("v%0d_addr", i), bus.imem_addr, vq[i].eaddr);
      @(negedge clk);
    end

    // Reset while a request waits: req drops at once, a late ack is ignored.
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("wait_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("wait_addr", bus.imem_addr, 32'h94);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, bus.if_valid}, 32'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'hBAD4);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("restart_addr",  bus.imem_addr, 32'h0);
    chk("lateack_valid", {31'b0, bus.if_valid}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h5000);
    @(posedge clk);
    #1;
    chk("restart_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("restart_pc",    bus.if_pc, 32'h0);
    chk("restart_instr", bus.if_instr, 32'h5000);

    // Randomized run: every instruction decode accepts must follow program order
    // (sequential +4 from reset or from the latest redirect target).
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    exp_pc    = 32'h0;
    lat       = 0;
    consumed  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_req && !prev_ack) begin
        chk("req_hold",  {31'b0, bus.imem_req}, 32'd1);
        chk("addr_hold", bus.imem_addr, prev_addr);
      end
      stall_v = ($urandom_range(0, 3) == 0);
      br_v    = ($urandom_range(0, 11) == 0);
      tgt_v   = $urandom;
      if (bus.if_valid && !stall_v) begin
        chk("rand_pc",    bus.if_pc, exp_pc);
        chk("rand_instr", bus.if_instr, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end else if (!bus.if_valid) begin
        chk("rand_nop", bus.if_instr, NOP);
      end
      if (br_v) exp_pc = tgt_v & ~32'h3;

      if (bus.imem_req) begin
        if (!(prev_req && !prev_ack)) lat = $urandom_range(0, 2);
        ack_v = (lat == 0);
        if (!ack_v) lat--;
        rdata_v = ack_v ? memf(bus.imem_addr) : $urandom;
      end else begin
        ack_v   = ($urandom_range(0, 1) == 1);
        rdata_v = $urandom;
      end
      prev_req  = bus.imem_req;
      prev_ack  = ack_v;
      prev_addr = bus.imem_addr;
      drive(stall_v, br_v, tgt_v, ack_v, rdata_v);
    end
    chk("progress", {31'b0, (consumed > 100)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
